// File: rtl/mynios2_cpu_jtag_debug_cmd_bridge_if.sv
// Command handshake between the JTAG debug bridge and the CPU debug logic.
// The head entry is offered with valid/ready; data and IR travel with it.
interface mynios2_cpu_jtag_debug_cmd_bridge_if #(
    parameter int DATA_W = 38,
    parameter int IR_W   = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [IR_W-1:0]   cmd_ir;

    modport master (output cmd_valid, output cmd_data, output cmd_ir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, input cmd_ir, output cmd_ready);
endinterface

// File: rtl/mynios2_cpu_jtag_debug_cmd_bridge.sv
// System-clock half of the JTAG debug module: synchronises update-DR/IR strobes,
// queues {ir_in, sr} in a FWFT FIFO and decodes per-channel action pulses on pop.
module mynios2_cpu_jtag_debug_cmd_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int ACTION_BIT  = 37,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DATA_W-1:0]        sr,
    input  logic                     clear_ovf,
    mynios2_cpu_jtag_debug_cmd_bridge_if.master cmd,
    output logic [(2**IR_W)-1:0]     take_action,
    output logic [(2**IR_W)-1:0]     take_no_action,
    output logic                     ir_update,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_last;
    logic                   uir_last;
    logic                   udr_pulse;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [IR_W-1:0]   mem_ir   [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] hold_data;
    logic [IR_W-1:0]   hold_ir;
    logic [DATA_W-1:0] head_data;
    logic [IR_W-1:0]   head_ir;
    logic              head_vld;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    assign armed = (arm_cnt == ARM_W'(ARM_MAX));

    // Strobe synchronisers and edge detect; pulses stay masked until the chains
    // have flushed, so a level already high at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            udr_last  <= 1'b0;
            uir_last  <= 1'b0;
            udr_pulse <= 1'b0;
            ir_update <= 1'b0;
            arm_cnt   <= '0;
        end else begin
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_last  <= udr_sync[SYNC_STAGES-1];
            uir_last  <= uir_sync[SYNC_STAGES-1];
            udr_pulse <= armed & udr_sync[SYNC_STAGES-1] & ~udr_last;
            ir_update <= armed & uir_sync[SYNC_STAGES-1] & ~uir_last;
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    assign head_vld  = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign head_data = mem_data[rd_ptr];
    assign head_ir   = mem_ir[rd_ptr];
    assign pop       = head_vld & cmd.cmd_ready;
    assign push      = udr_pulse & (~full | pop);
    assign drop      = udr_pulse & full & ~pop;

    // A push into a full FIFO with a coincident pop overwrites the slot being read out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sr;
            mem_ir[wr_ptr]   <= ir_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_data  <= '0;
            hold_ir    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                hold_data <= head_data;
                hold_ir   <= head_ir;
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            // A drop in the same cycle as clear_ovf restarts the count at one.
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clear_ovf ? 8'd1 : sat_inc(drop_count);
            end else if (clear_ovf) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

    assign cmd.cmd_valid = head_vld;
    assign cmd.cmd_data  = head_vld ? head_data : hold_data;
    assign cmd.cmd_ir    = head_vld ? head_ir : hold_ir;
    assign fill_level    = count;

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (pop) begin
            if (head_data[ACTION_BIT]) begin
                take_action[head_ir] = 1'b1;
            end else begin
                take_no_action[head_ir] = 1'b1;
            end
        end
    end
endmodule
